// File: rtl/apb_slave_mem_if.sv
// APB bus bundle (8-bit data, 9-bit address) between the master and a byte-memory completer.
interface apb_slave_mem_if;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [8:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer with a byte-wide register memory, fixed wait states and PSLVERR on
// out-of-range offsets or an access phase that arrives without a setup phase.
module apb_slave_mem #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  i_pclk,
   input  logic                  i_presetn,
   apb_slave_mem_if.slave        io_apb
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_WAIT,
      S_DONE
   } state_t;

   localparam bit       ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam bit [3:0] CNT_LOAD  = 4'(WAIT_CYCLES);

   state_t     r_state;
   state_t     w_state_next;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_next;

   logic [7:0] r_addr;
   logic       r_write;
   logic [7:0] r_wdata;
   logic       r_err;

   logic [7:0] r_prdata;
   logic       r_pready;
   logic       r_pslverr;

   logic [7:0] r_mem [DEPTH];

   logic       w_setup;
   logic       w_access;
   logic       w_in_err;
   logic       w_capture;
   logic       w_enter_done;
   logic       w_proto_err;
   logic [7:0] w_fin_addr;
   logic       w_fin_write;
   logic [7:0] w_fin_wdata;
   logic       w_fin_err;
   logic       w_mem_we;
   logic       w_rd_en;
   logic [7:0] w_rd_data;
   logic [DEPTH-1:0] w_hit;
   logic       w_unused_paddr_msb;

   assign w_setup            = io_apb.psel & ~io_apb.penable;
   assign w_access           = io_apb.psel &  io_apb.penable;
   assign w_in_err           = ({1'b0, io_apb.paddr[7:0]} >= 9'(DEPTH));
   assign w_unused_paddr_msb = io_apb.paddr[8];

   // The completing transfer may be captured at this very edge (zero wait states,
   // or back-to-back setup in DONE), so the live inputs bypass the capture registers.
   assign w_fin_addr  = w_capture ? io_apb.paddr[7:0] : r_addr;
   assign w_fin_write = w_capture ? io_apb.pwrite     : r_write;
   assign w_fin_wdata = w_capture ? io_apb.pwdata     : r_wdata;
   assign w_fin_err   = w_capture ? w_in_err          : r_err;

   assign w_mem_we = w_enter_done & ~w_proto_err &  w_fin_write & ~w_fin_err;
   assign w_rd_en  = w_enter_done & ~w_proto_err & ~w_fin_write;

   always_ff @(posedge i_pclk) begin
      if (!i_presetn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_capture    = 1'b0;
      w_enter_done = 1'b0;
      w_proto_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_setup) begin
               w_capture = 1'b1;
               if (ZERO_WAIT) begin
                  w_state_next = S_DONE;
                  w_enter_done = 1'b1;
               end else begin
                  w_state_next = S_SETUP;
               end
            end else if (w_access) begin
               w_state_next = S_DONE;
               w_enter_done = 1'b1;
               w_proto_err  = 1'b1;
            end
         end
         S_SETUP: begin
            if (!io_apb.psel) begin
               w_state_next = S_IDLE;
            end else if (!io_apb.penable) begin
               w_capture = 1'b1;
            end else if (r_cnt <= 4'd1) begin
               w_cnt_next   = '0;
               w_state_next = S_DONE;
               w_enter_done = 1'b1;
            end else begin
               w_cnt_next   = r_cnt - 4'd1;
               w_state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!io_apb.psel) begin
               w_state_next = S_IDLE;
            end else if (r_cnt <= 4'd1) begin
               w_cnt_next   = '0;
               w_state_next = S_DONE;
               w_enter_done = 1'b1;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         S_DONE: begin
            if (w_setup) begin
               w_capture = 1'b1;
               if (ZERO_WAIT) begin
                  w_state_next = S_DONE;
                  w_enter_done = 1'b1;
               end else begin
                  w_state_next = S_SETUP;
               end
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      if (w_capture) begin
         w_cnt_next = CNT_LOAD;
      end
   end

   always_ff @(posedge i_pclk) begin
      if (!i_presetn) begin
         r_addr  <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else if (w_capture) begin
         r_addr  <= io_apb.paddr[7:0];
         r_write <= io_apb.pwrite;
         r_wdata <= io_apb.pwdata;
         r_err   <= w_in_err;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
         assign w_hit[gi] = (w_fin_addr == 8'(gi));
      end
   endgenerate

   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_hit[i]) begin
            w_rd_data = r_mem[i];
         end
      end
   end

   always_ff @(posedge i_pclk) begin
      if (!i_presetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_mem_we) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_hit[i]) begin
               r_mem[i] <= w_fin_wdata;
            end
         end
      end
   end

   // Protocol errors and writes leave PRDATA alone; errored reads return zero.
   always_ff @(posedge i_pclk) begin
      if (!i_presetn) begin
         r_prdata  <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
      end else begin
         r_pready  <= w_enter_done;
         r_pslverr <= w_enter_done & (w_proto_err | w_fin_err);
         if (w_rd_en) begin
            r_prdata <= w_fin_err ? 8'h00 : w_rd_data;
         end
      end
   end

   assign io_apb.prdata  = r_prdata;
   assign io_apb.pready  = r_pready;
   assign io_apb.pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances (0, 3 and 2 wait states) behind one driver.
module tb_apb_slave_mem;

   logic       clk = 1'b0;
   logic       presetn;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [8:0] paddr;
   logic [7:0] pwdata;
   int         sel;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   apb_slave_mem_if if_w0 ();
   apb_slave_mem_if if_w3 ();
   apb_slave_mem_if if_w2 ();

   assign if_w0.psel = psel && (sel == 0);
   assign if_w3.psel = psel && (sel == 1);
   assign if_w2.psel = psel && (sel == 2);
   assign if_w0.penable = penable;
   assign if_w3.penable = penable;
   assign if_w2.penable = penable;
   assign if_w0.pwrite = pwrite;
   assign if_w3.pwrite = pwrite;
   assign if_w2.pwrite = pwrite;
   assign if_w0.paddr = paddr;
   assign if_w3.paddr = paddr;
   assign if_w2.paddr = paddr;
   assign if_w0.pwdata = pwdata;
   assign if_w3.pwdata = pwdata;
   assign if_w2.pwdata = pwdata;

   assign prdata  = (sel == 0) ? if_w0.prdata  : (sel == 1) ? if_w3.prdata  : if_w2.prdata;
   assign pready  = (sel == 0) ? if_w0.pready  : (sel == 1) ? if_w3.pready  : if_w2.pready;
   assign pslverr = (sel == 0) ? if_w0.pslverr : (sel == 1) ? if_w3.pslverr : if_w2.pslverr;

   apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut_w0 (
      .i_pclk    (clk),
      .i_presetn (presetn),
      .io_apb    (if_w0)
   );

   apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(3)) u_dut_w3 (
      .i_pclk    (clk),
      .i_presetn (presetn),
      .io_apb    (if_w3)
   );

   apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut_w2 (
      .i_pclk    (clk),
      .i_presetn (presetn),
      .io_apb    (if_w2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One APB transfer starting at the current cycle (C0). Access-phase address and
   // data are scrambled so only the captured setup values can produce the right result.
   // With overlap set, returns at the start of the expected completion cycle with the
   // bus still in access, so the caller can place the next setup in that cycle.
   task automatic xfer(input int unit, input bit wr, input logic [8:0] addr,
                       input logic [7:0] wd, input int n_wait, input bit exp_err,
                       input logic [7:0] exp_rd, input bit overlap, input string tag);
      int k;
      sel     = unit;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wd;
      @(posedge clk);
      #1;
      penable = 1'b1;
      paddr   = addr ^ 9'h001;
      pwdata  = ~wd;
      if (overlap) begin
         repeat (n_wait) @(posedge clk);
         #1;
         $display("xfer %-12s unit=%0d %s addr=0x%03h overlapped with next setup",
                  tag, unit, wr ? "WR" : "RD", addr);
         return;
      end
      k = 1;
      @(negedge clk);
      while (pready !== 1'b1 && k <= 20) begin
         chk({tag, "/err_low"}, 32'(pslverr), 32'd0);
         k++;
         @(negedge clk);
      end
      chk({tag, "/latency"}, 32'(k), 32'(n_wait + 1));
      chk({tag, "/pslverr"}, 32'(pslverr), 32'(exp_err));
      if (!wr) begin
         chk({tag, "/prdata"}, 32'(prdata), 32'(exp_rd));
      end
      $display("xfer %-12s unit=%0d %s addr=0x%03h ready_in_C%0d err=%0b rdata=0x%02h",
               tag, unit, wr ? "WR" : "RD", addr, k, pslverr, prdata);
      @(posedge clk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      presetn = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      sel     = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
         sel = u;
         #1;
         chk("reset/pready", 32'(pready), 32'd0);
         chk("reset/pslverr", 32'(pslverr), 32'd0);
         chk("reset/prdata", 32'(prdata), 32'd0);
      end
      presetn = 1'b1;
      @(posedge clk);
      #1;

      // Basic write/read, zero wait states
      xfer(0, 1'b1, 9'h010, 8'hA5, 0, 1'b0, 8'h00, 1'b0, "w0_wr10");
      xfer(0, 1'b0, 9'h010, 8'h00, 0, 1'b0, 8'hA5, 1'b0, "w0_rd10");

      // Three wait states
      xfer(1, 1'b1, 9'h005, 8'h3C, 3, 1'b0, 8'h00, 1'b0, "w3_wr05");
      xfer(1, 1'b0, 9'h005, 8'h00, 3, 1'b0, 8'h3C, 1'b0, "w3_rd05");

      // Out of range and boundary offsets; PADDR[8] ignored
      xfer(0, 1'b1, 9'h040, 8'hFF, 0, 1'b1, 8'h00, 1'b0, "w0_wr40");
      xfer(0, 1'b0, 9'h040, 8'h00, 0, 1'b1, 8'h00, 1'b0, "w0_rd40");
      xfer(0, 1'b0, 9'h000, 8'h00, 0, 1'b0, 8'h00, 1'b0, "w0_rd00");
      xfer(0, 1'b0, 9'h010, 8'h00, 0, 1'b0, 8'hA5, 1'b0, "w0_rd10b");
      xfer(0, 1'b1, 9'h13F, 8'h5E, 0, 1'b0, 8'h00, 1'b0, "w0_wr13F");
      xfer(0, 1'b0, 9'h03F, 8'h00, 0, 1'b0, 8'h5E, 1'b0, "w0_rd3F");

      // Back-to-back transfers
      xfer(0, 1'b1, 9'h001, 8'h11, 0, 1'b0, 8'h00, 1'b0, "b2b_wr01");
      xfer(0, 1'b1, 9'h002, 8'h22, 0, 1'b0, 8'h00, 1'b0, "b2b_wr02");
      xfer(0, 1'b0, 9'h001, 8'h00, 0, 1'b0, 8'h11, 1'b0, "b2b_rd01");
      xfer(0, 1'b0, 9'h002, 8'h00, 0, 1'b0, 8'h22, 1'b0, "b2b_rd02");

      // Next setup placed in the completion cycle of a waited write
      xfer(1, 1'b1, 9'h020, 8'h44, 3, 1'b0, 8'h00, 1'b1, "ovl_wr20");
      xfer(1, 1'b0, 9'h020, 8'h00, 3, 1'b0, 8'h44, 1'b0, "ovl_rd20");

      // Abort in C1 on the two-wait-state instance
      sel     = 2;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 9'h008;
      pwdata  = 8'h77;
      @(posedge clk);
      #1;
      psel = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort/pready", 32'(pready), 32'd0);
      end
      $display("xfer %-12s unit=2 WR addr=0x008 aborted in C1", "abort_wr08");
      @(posedge clk);
      #1;
      xfer(2, 1'b0, 9'h008, 8'h00, 2, 1'b0, 8'h00, 1'b0, "abort_rd08");

      // Reset in the last wait cycle of a write (PRDATA of unit 1 is 8'h44 here)
      sel     = 1;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 9'h009;
      pwdata  = 8'h5A;
      @(posedge clk);
      #1;
      penable = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      presetn = 1'b0;
      @(posedge clk);
      #1;
      presetn = 1'b1;
      psel    = 1'b0;
      penable = 1'b0;
      @(negedge clk);
      chk("rst_mid/pready", 32'(pready), 32'd0);
      chk("rst_mid/pslverr", 32'(pslverr), 32'd0);
      chk("rst_mid/prdata", 32'(prdata), 32'd0);
      $display("xfer %-12s unit=1 WR addr=0x009 cut by reset", "rst_wr09");
      @(posedge clk);
      #1;
      xfer(1, 1'b0, 9'h009, 8'h00, 3, 1'b0, 8'h00, 1'b0, "rst_rd09");
      xfer(1, 1'b0, 9'h005, 8'h00, 3, 1'b0, 8'h00, 1'b0, "rst_rd05");

      // Access phase straight from IDLE
      xfer(0, 1'b1, 9'h010, 8'hC3, 0, 1'b0, 8'h00, 1'b0, "pe_wr10");
      xfer(0, 1'b0, 9'h010, 8'h00, 0, 1'b0, 8'hC3, 1'b0, "pe_rd10");
      sel     = 0;
      psel    = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b0;
      paddr   = 9'h011;
      @(negedge clk);
      chk("pe_rd/idle_pready", 32'(pready), 32'd0);
      @(posedge clk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
      @(negedge clk);
      chk("pe_rd/pready", 32'(pready), 32'd1);
      chk("pe_rd/pslverr", 32'(pslverr), 32'd1);
      chk("pe_rd/prdata", 32'(prdata), 32'hC3);
      $display("xfer %-12s unit=0 RD addr=0x011 no setup phase", "pe_rd11");
      @(negedge clk);
      chk("pe_rd/pready_clr", 32'(pready), 32'd0);
      chk("pe_rd/pslverr_clr", 32'(pslverr), 32'd0);
      @(posedge clk);
      #1;
      psel    = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b1;
      paddr   = 9'h010;
      pwdata  = 8'h99;
      @(posedge clk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
      @(negedge clk);
      chk("pe_wr/pready", 32'(pready), 32'd1);
      chk("pe_wr/pslverr", 32'(pslverr), 32'd1);
      $display("xfer %-12s unit=0 WR addr=0x010 no setup phase", "pe_wr10x");
      @(posedge clk);
      #1;
      xfer(0, 1'b0, 9'h010, 8'h00, 0, 1'b0, 8'hC3, 1'b0, "pe_rd10b");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
